// File: rtl/half_duplex_spi_slave.sv
// 3-wire SPI responder oversampled in fabric_clk: decodes rw/addr/data frames
// and turns them into single-cycle register read/write strobes.
module half_duplex_spi_slave #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  fabric_clk,
  input  logic                  reset_n,
  input  logic                  spi_cpol,
  input  logic                  spi_cpha,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  inout  wire                   spi_sdio,
  output logic                  sdio_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  busy,
  output logic                  frame_error
);

  localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_RD_LOAD = 3'd4;
  localparam logic [2:0] S_RD_DATA = 3'd5;
  localparam logic [2:0] S_WAIT_CS = 3'd6;

  logic [2:0]            sclk_sync_q, cs_sync_q;
  logic [1:0]            sdio_sync_q;
  logic [2:0]            state_q, state_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic                  rw_q, rw_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  first_q, first_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d, addr_next;
  logic [DATA_WIDTH-1:0] data_sh_q, data_sh_d, data_next;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_wr_data_q, reg_wr_data_d;
  logic                  sdio_oe_q, sdio_oe_d;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic                  ferr_q, ferr_d, busy_q, busy_d;

  logic sclk_now, sclk_prev, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, sdio_s;

  // Edge detection on the polarity-normalised, synchronised SCLK
  assign sclk_now    = sclk_sync_q[1] ^ cpol_q;
  assign sclk_prev   = sclk_sync_q[2] ^ cpol_q;
  assign lead_edge   = sclk_now & ~sclk_prev;
  assign trail_edge  = ~sclk_now & sclk_prev;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  assign cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
  assign sdio_s      = sdio_sync_q[1];
  assign addr_next   = ADDR_WIDTH'({addr_sh_q, sdio_s});
  assign data_next   = DATA_WIDTH'({data_sh_q, sdio_s});

  assign spi_sdio    = sdio_oe_q ? data_sh_q[DATA_WIDTH-1] : 1'bz;
  assign sdio_oe     = sdio_oe_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_rd_en   = rd_en_q;
  assign busy        = busy_q;
  assign frame_error = ferr_q;

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      sdio_sync_q   <= '0;
      state_q       <= S_IDLE;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      rw_q          <= 1'b0;
      rd_pend_q     <= 1'b0;
      first_q       <= 1'b0;
      bit_cnt_q     <= '0;
      addr_sh_q     <= '0;
      data_sh_q     <= '0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      sdio_oe_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      ferr_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sclk_sync_q   <= {sclk_sync_q[1:0], spi_sclk};
      cs_sync_q     <= {cs_sync_q[1:0], spi_cs_n};
      sdio_sync_q   <= {sdio_sync_q[0], spi_sdio};
      state_q       <= state_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      rw_q          <= rw_d;
      rd_pend_q     <= rd_pend_d;
      first_q       <= first_d;
      bit_cnt_q     <= bit_cnt_d;
      addr_sh_q     <= addr_sh_d;
      data_sh_q     <= data_sh_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      sdio_oe_q     <= sdio_oe_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      ferr_q        <= ferr_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    rw_d          = rw_q;
    rd_pend_d     = rd_pend_q;
    first_d       = first_q;
    bit_cnt_d     = bit_cnt_q;
    addr_sh_d     = addr_sh_q;
    data_sh_d     = data_sh_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    sdio_oe_d     = sdio_oe_q;
    wr_en_d       = 1'b0;
    rd_en_d       = 1'b0;
    ferr_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        cpol_d    = spi_cpol;
        cpha_d    = spi_cpha;
        sdio_oe_d = 1'b0;
        if (cs_fall) state_d = S_CMD;
      end
      S_CMD: begin
        if (sample_edge) begin
          rw_d      = sdio_s;
          bit_cnt_d = CNT_W'(ADDR_WIDTH - 1);
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (sample_edge) begin
          addr_sh_d = addr_next;
          if (bit_cnt_q == '0) begin
            reg_addr_d = addr_next;
            if (rw_q) begin
              rd_en_d   = 1'b1;
              rd_pend_d = 1'b1;
              state_d   = S_RD_LOAD;
            end else begin
              bit_cnt_d = CNT_W'(DATA_WIDTH - 1);
              state_d   = S_WR_DATA;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
          end
        end
      end
      S_WR_DATA: begin
        if (sample_edge) begin
          data_sh_d = data_next;
          if (bit_cnt_q == '0) begin
            reg_wr_data_d = data_next;
            wr_en_d       = 1'b1;
            state_d       = S_WAIT_CS;
          end else begin
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
          end
        end
      end
      // First cycle waits for the fabric read latency, second captures the word
      S_RD_LOAD: begin
        if (rd_pend_q) begin
          rd_pend_d = 1'b0;
        end else begin
          data_sh_d = reg_rd_data;
          sdio_oe_d = 1'b1;
          bit_cnt_d = CNT_W'(DATA_WIDTH - 1);
          first_d   = 1'b0;
          state_d   = S_RD_DATA;
        end
      end
      // MSB is already on the line; shifting starts only after it was sampled
      S_RD_DATA: begin
        if (sample_edge) begin
          first_d = 1'b1;
          if (bit_cnt_q == '0) begin
            sdio_oe_d = 1'b0;
            state_d   = S_WAIT_CS;
          end else begin
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
          end
        end else if (shift_edge && first_q) begin
          data_sh_d = data_sh_q << 1;
        end
      end
      S_WAIT_CS: begin
        sdio_oe_d = 1'b0;
        if (cs_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cs_rise && (state_q inside {S_CMD, S_ADDR, S_WR_DATA, S_RD_LOAD, S_RD_DATA})) begin
      state_d   = S_IDLE;
      ferr_d    = 1'b1;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      sdio_oe_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_half_duplex_spi_slave.sv
// Directed bench: bit-banged SPI master, register-file responder and an
// access scoreboard comparing expected against observed strobes.
module tb_half_duplex_spi_slave;

  localparam int H = 8;

  logic        fabric_clk = 1'b0;
  logic        reset_n;
  logic        spi_cpol, spi_cpha, spi_sclk, spi_cs_n;
  wire         spi_sdio;
  logic        sdio_oe;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic        reg_wr_en, reg_rd_en;
  logic [15:0] reg_rd_data = 16'hDEAD;
  logic        busy, frame_error;

  logic        drv_en, drv_val;
  assign spi_sdio = drv_en ? drv_val : 1'bz;

  half_duplex_spi_slave dut (
    .fabric_clk(fabric_clk), .reset_n(reset_n),
    .spi_cpol(spi_cpol), .spi_cpha(spi_cpha), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_sdio(spi_sdio), .sdio_oe(sdio_oe),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .busy(busy), .frame_error(frame_error)
  );

  always #5 fabric_clk = ~fabric_clk;

  // Register file responder: read data valid exactly one cycle after the strobe
  logic [15:0] mem [0:127];
  always @(posedge fabric_clk) begin
    if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
    reg_rd_data <= reg_rd_en ? mem[reg_addr] : 16'hDEAD;
  end

  // Observed accesses: {wr, addr, data}; reads carry zero data
  logic [23:0] obs_q [$];
  int          ferr_cnt = 0;
  int          oe_cycles = 0;
  always @(negedge fabric_clk) begin
    if (reg_wr_en) obs_q.push_back({1'b1, reg_addr, reg_wr_data});
    if (reg_rd_en) obs_q.push_back({1'b0, reg_addr, 16'h0000});
    if (frame_error) ferr_cnt++;
    if (sdio_oe) oe_cycles++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [23:0] exp_q [$];
  int          obs_rd = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge fabric_clk);
  endtask

  task automatic compare_accesses(input string tag);
    logic [23:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        o = obs_q[obs_rd];
        obs_rd++;
      end else begin
        o = '1;
      end
      check({tag, "_acc"}, 32'(o), 32'(e));
    end
    check({tag, "_extra"}, 32'(obs_q.size() - obs_rd), 32'd0);
  endtask

  task automatic drive_bit(input int i, input logic rw, input logic [23:0] fr);
    if (i < 24 && (!rw || i < 8)) begin
      drv_en  = 1'b1;
      drv_val = fr[23-i];
    end else begin
      drv_en = 1'b0;
    end
  endtask

  task automatic set_mode(input logic cpol, input logic cpha);
    spi_cpol = cpol;
    spi_cpha = cpha;
    spi_sclk = cpol;
    cyc(H);
  endtask

  // Master frame: nclk SCLK periods; for reads the master releases SDIO after the address
  task automatic spi_xfer(input logic rw, input logic [6:0] addr, input logic [15:0] wd,
                          input int nclk, input bit raise_cs, output logic [15:0] rd);
    logic [23:0] fr;
    fr = {rw, addr, wd};
    rd = '0;
    spi_cs_n = 1'b0;
    cyc(H);
    for (int i = 0; i < nclk; i++) begin
      if (!spi_cpha) begin
        drive_bit(i, rw, fr);
        cyc(H);
        if (rw && i >= 8 && i < 24) rd[23-i] = spi_sdio;
        spi_sclk = ~spi_cpol;
        cyc(3);
        if (rw && i == 7) drv_en = 1'b0;
        cyc(H - 3);
        spi_sclk = spi_cpol;
      end else begin
        spi_sclk = ~spi_cpol;
        drive_bit(i, rw, fr);
        cyc(H);
        if (rw && i >= 8 && i < 24) rd[23-i] = spi_sdio;
        spi_sclk = spi_cpol;
        cyc(3);
        if (rw && i == 7) drv_en = 1'b0;
        cyc(H - 3);
      end
    end
    cyc(H);
    if (raise_cs) begin
      drv_en   = 1'b0;
      spi_cs_n = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] rd;
    int          oe0, fe0;

    reset_n  = 1'b0;
    spi_cpol = 1'b0;
    spi_cpha = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    drv_en   = 1'b0;
    drv_val  = 1'b0;
    cyc(5);
    check("rst_oe", 32'(sdio_oe), 32'd0);
    check("rst_strobes", 32'({reg_wr_en, reg_rd_en, frame_error, busy}), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_wdata", 32'(reg_wr_data), 32'd0);
    reset_n = 1'b1;
    cyc(8);

    // Write, mode 0
    oe0 = oe_cycles;
    exp_q.push_back({1'b1, 7'h15, 16'hA5C3});
    spi_xfer(1'b0, 7'h15, 16'hA5C3, 24, 1'b1, rd);
    cyc(8);
    compare_accesses("wr_mode0");
    check("wr_no_oe", 32'(oe_cycles - oe0), 32'd0);
    check("wr_busy_done", 32'(busy), 32'd0);

    // Preload the read target through the bus itself
    exp_q.push_back({1'b1, 7'h2A, 16'h1234});
    spi_xfer(1'b0, 7'h2A, 16'h1234, 24, 1'b1, rd);
    cyc(8);
    compare_accesses("preload");

    // Read in all four modes
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0]);
      exp_q.push_back({1'b0, 7'h2A, 16'h0000});
      spi_xfer(1'b1, 7'h2A, 16'h0000, 24, 1'b1, rd);
      check($sformatf("rd_data_m%0d", m), 32'(rd), 32'h1234);
      cyc(3);
      check($sformatf("rd_release_m%0d", m), 32'(sdio_oe), 32'd0);
      cyc(8);
      compare_accesses($sformatf("rd_m%0d", m));
    end

    // Abort after 10 bits of a write, then a good write
    set_mode(1'b0, 1'b0);
    fe0 = ferr_cnt;
    spi_xfer(1'b0, 7'h33, 16'hFFFF, 10, 1'b1, rd);
    cyc(8);
    check("abort_ferr", 32'(ferr_cnt - fe0), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    compare_accesses("abort");
    exp_q.push_back({1'b1, 7'h33, 16'hBEEF});
    spi_xfer(1'b0, 7'h33, 16'hBEEF, 24, 1'b1, rd);
    cyc(8);
    compare_accesses("post_abort_wr");

    // 30 clocks in one read frame
    fe0 = ferr_cnt;
    exp_q.push_back({1'b0, 7'h2A, 16'h0000});
    spi_xfer(1'b1, 7'h2A, 16'h0000, 30, 1'b1, rd);
    check("extra_rd_data", 32'(rd), 32'h1234);
    cyc(3);
    check("extra_release", 32'(sdio_oe), 32'd0);
    cyc(8);
    check("extra_no_ferr", 32'(ferr_cnt - fe0), 32'd0);
    compare_accesses("extra");

    // Reset in the middle of the read data phase
    set_mode(1'b0, 1'b1);
    exp_q.push_back({1'b0, 7'h33, 16'h0000});
    spi_xfer(1'b1, 7'h33, 16'h0000, 12, 1'b0, rd);
    check("midrd_oe_before", 32'(sdio_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrd_oe_reset", 32'(sdio_oe), 32'd0);
    check("midrd_strobes_reset", 32'({reg_wr_en, reg_rd_en, frame_error, busy}), 32'd0);
    cyc(2);
    spi_cs_n = 1'b1;
    cyc(4);
    reset_n = 1'b1;
    cyc(8);
    compare_accesses("midrd");
    exp_q.push_back({1'b0, 7'h33, 16'h0000});
    spi_xfer(1'b1, 7'h33, 16'h0000, 24, 1'b1, rd);
    check("post_reset_rd", 32'(rd), 32'hBEEF);
    cyc(8);
    compare_accesses("post_reset");

    // Back-to-back frames with minimum CS_N gap
    set_mode(1'b0, 1'b0);
    exp_q.push_back({1'b1, 7'h01, 16'h0001});
    exp_q.push_back({1'b0, 7'h01, 16'h0000});
    spi_xfer(1'b0, 7'h01, 16'h0001, 24, 1'b1, rd);
    cyc(4);
    spi_xfer(1'b1, 7'h01, 16'h0000, 24, 1'b1, rd);
    check("b2b_rd_data", 32'(rd), 32'h0001);
    cyc(8);
    compare_accesses("b2b");
    check("total_ferr", 32'(ferr_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
